// File: rtl/serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serializer_tx
//  Purpose  : Parallel-to-serial transmitter for the ANN weight/activation link.
//             Bytes enter through a valid/ready handshake into a small FIFO and
//             leave MSB-first, one bit per clock, qualified by data_ready.
//             There are no framing bits: each byte is exactly DATA_W strobes.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous, active-high reset
//             din        - parallel byte to send
//             din_valid  - din is valid this cycle
//             din_ready  - FIFO can accept (not full)
//             ser_out    - serial data bit, MSB first (0 when data_ready=0)
//             data_ready - ser_out carries a valid bit this cycle
//             frame_done - 1-cycle pulse with the last (LSB) bit of a byte
//             busy       - FIFO non-empty or transmission in progress
//             fifo_count - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module serializer_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          ser_out,
    output logic                          data_ready,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       c_GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W:0]   c_FULL     = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [DATA_W-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [PTR_W:0]      count_q,   count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                w_push;
    logic                w_pop;
    logic                w_empty;

    // Full/empty come from the registered occupancy only; the pointers simply
    // wrap modulo FIFO_DEPTH.
    assign w_empty = (count_q == '0);
    assign w_push  = din_valid && (count_q != c_FULL);

    // ------------------------------------------------------------------------
    // Next-state logic. The pop decision lives here so that a pop only ever
    // sees data already stored on a previous edge (no same-edge bypass).
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        w_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == c_LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else if (!w_empty) begin
                        // Chain straight into the next byte: no bubble.
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Outputs are decoded purely from registered state, so they change only
    // on the clock edge. ser_out is forced low outside of SHIFT.
    assign data_ready = (state_q == S_SHIFT);
    assign ser_out    = data_ready & shift_q[DATA_W-1];
    assign frame_done = data_ready && (bit_cnt_q == c_LAST_BIT);
    assign busy       = (state_q != S_IDLE) || !w_empty;
    assign din_ready  = (count_q != c_FULL);
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serializer_tx
//  Purpose  : Directed self-checking bench for serializer_tx. Two instances:
//             u_dut (GAP_CYCLES=0) and u_dut_gap (GAP_CYCLES=3). Output
//             activity is logged per cycle and decoded by a small reference
//             deserializer that rebuilds bytes MSB-first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       rdy_a, so_a, dr_a, fd_a, bz_a;
    logic       rdy_b, so_b, dr_b, fd_b, bz_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    serializer_tx #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .reset(reset), .din(din_a), .din_valid(valid_a),
        .din_ready(rdy_a), .ser_out(so_a), .data_ready(dr_a),
        .frame_done(fd_a), .busy(bz_a), .fifo_count(cnt_a)
    );

    serializer_tx #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(3)) u_dut_gap (
        .clk(clk), .reset(reset), .din(din_b), .din_valid(valid_b),
        .din_ready(rdy_b), .ser_out(so_b), .data_ready(dr_b),
        .frame_done(fd_b), .busy(bz_b), .fifo_count(cnt_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       rec_on   = 1'b0;
    logic       rec_sel  = 1'b0;
    logic       log_dr[$], log_so[$], log_fd[$], log_bz[$];
    logic [7:0] exp_bytes[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rec_on) begin
            if (!rec_sel) begin
                log_dr.push_back(dr_a); log_so.push_back(so_a);
                log_fd.push_back(fd_a); log_bz.push_back(bz_a);
            end else begin
                log_dr.push_back(dr_b); log_so.push_back(so_b);
                log_fd.push_back(fd_b); log_bz.push_back(bz_b);
            end
        end
    endtask

    task automatic start_log(input logic sel);
        log_dr.delete(); log_so.delete(); log_fd.delete(); log_bz.delete();
        rec_sel = sel;
        rec_on  = 1'b1;
    endtask

    // Reference deserializer over the log: rebuilds bytes from data_ready
    // strobes, checks frame_done placement, ser_out=0 when idle, and the
    // length of every idle run between bytes (exp_gap<0: none allowed).
    task automatic analyze(input string tag, input int exp_start, input int exp_gap);
        int         first, nbits, fd_bad, so_bad, run, gap_bad, n_gaps, exp_ngaps;
        logic [7:0] sh;
        logic [7:0] got_q[$];
        first = -1; nbits = 0; fd_bad = 0; so_bad = 0;
        run = 0; gap_bad = 0; n_gaps = 0; sh = 8'h00;
        for (int i = 0; i < log_dr.size(); i++) begin
            if (log_dr[i]) begin
                if (first < 0) first = i;
                if (run > 0) begin
                    n_gaps++;
                    if (run != exp_gap) gap_bad++;
                    run = 0;
                end
                sh = {sh[6:0], log_so[i]};
                nbits++;
                if (log_fd[i] != ((nbits % 8) == 0)) fd_bad++;
                if ((nbits % 8) == 0) got_q.push_back(sh);
            end else begin
                if (first >= 0) run++;
                if (log_fd[i] || log_so[i]) so_bad++;
            end
        end
        exp_ngaps = (exp_gap < 0) ? 0 : exp_bytes.size() - 1;
        check_eq({tag, ".start"}, 32'(first), 32'(exp_start));
        check_eq({tag, ".nbits"}, 32'(nbits), 32'(8 * exp_bytes.size()));
        for (int k = 0; k < exp_bytes.size(); k++) begin
            check_eq($sformatf("%s.byte%0d", tag, k),
                     (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF_FFFF,
                     32'(exp_bytes[k]));
        end
        check_eq({tag, ".frame_done"}, 32'(fd_bad), 32'd0);
        check_eq({tag, ".idle_out"}, 32'(so_bad), 32'd0);
        check_eq({tag, ".gap_runs"}, 32'(n_gaps), 32'(exp_ngaps));
        check_eq({tag, ".gap_len"}, 32'(gap_bad), 32'd0);
        check_eq({tag, ".busy_end"}, 32'(log_bz[log_bz.size() - 1]), 32'd0);
        rec_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] full_bytes[6];
        int         k, max_cnt, viol, saw_full;
        logic       acc;

        reset = 1'b1; din_a = 8'h00; din_b = 8'h00; valid_a = 1'b0; valid_b = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state of both instances
        check_eq("rst.a", {27'd0, dr_a, so_a, fd_a, bz_a, rdy_a}, 32'h1);
        check_eq("rst.cnt_a", 32'(cnt_a), 32'd0);
        check_eq("rst.b", {27'd0, dr_b, so_b, fd_b, bz_b, rdy_b}, 32'h1);

        // din wiggling without valid has no effect
        din_a = 8'hDE; tick(); din_a = 8'hAD; tick();
        check_eq("novalid.cnt", 32'(cnt_a), 32'd0);
        check_eq("novalid.busy", 32'(bz_a), 32'd0);

        // Single byte 0xA5
        start_log(1'b0);
        din_a = 8'hA5; valid_a = 1'b1; tick(); valid_a = 1'b0;
        repeat (14) tick();
        check_eq("single.busy_queued", 32'(log_bz[0]), 32'd1);
        check_eq("single.busy_after", 32'(log_bz[9]), 32'd0);
        exp_bytes = '{8'hA5};
        analyze("single", 1, -1);

        // Back-to-back streaming with no gap
        start_log(1'b0);
        valid_a = 1'b1;
        din_a = 8'h3C; tick();
        din_a = 8'hFF; tick();
        din_a = 8'h00; tick();
        valid_a = 1'b0;
        repeat (30) tick();
        exp_bytes = '{8'h3C, 8'hFF, 8'h00};
        analyze("b2b", 1, -1);

        // Full FIFO with din_valid held high
        full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start_log(1'b0);
        k = 0; max_cnt = 0; viol = 0; saw_full = 0;
        for (int it = 0; it < 100 && k < 6; it++) begin
            din_a   = full_bytes[k];
            valid_a = 1'b1;
            acc     = rdy_a;
            tick();
            if (acc) k++;
            if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
            if (cnt_a == 3'd4) saw_full++;
            if (rdy_a != (cnt_a != 3'd4)) viol++;
        end
        valid_a = 1'b0;
        check_eq("full.accepted", 32'(k), 32'd6);
        check_eq("full.max_cnt", 32'(max_cnt), 32'd4);
        check_eq("full.ready_vs_cnt", 32'(viol), 32'd0);
        check_eq("full.reached", 32'(saw_full > 0), 32'd1);
        repeat (60) tick();
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        analyze("full", 1, -1);

        // Simultaneous push and pop with two entries held
        start_log(1'b0);
        valid_a = 1'b1;
        din_a = 8'h96; tick();
        din_a = 8'h4B; tick();
        din_a = 8'hE1; tick();
        valid_a = 1'b0;
        repeat (6) tick();
        check_eq("pp.pre_cnt", 32'(cnt_a), 32'd2);
        check_eq("pp.pre_lsb", {30'd0, dr_a, fd_a}, 32'h3);
        din_a = 8'h2D; valid_a = 1'b1; tick(); valid_a = 1'b0;
        check_eq("pp.cnt", 32'(cnt_a), 32'd2);
        repeat (40) tick();
        exp_bytes = '{8'h96, 8'h4B, 8'hE1, 8'h2D};
        analyze("pushpop", 1, -1);

        // Gap insertion on the GAP_CYCLES=3 instance: 3 gap + 1 idle cycle
        start_log(1'b1);
        valid_b = 1'b1;
        din_b = 8'h81; tick();
        din_b = 8'h7E; tick();
        valid_b = 1'b0;
        repeat (30) tick();
        exp_bytes = '{8'h81, 8'h7E};
        analyze("gap", 1, 4);

        // Reset mid-byte with a second byte still queued
        start_log(1'b0);
        valid_a = 1'b1;
        din_a = 8'hC3; tick();
        din_a = 8'hAA; tick();
        valid_a = 1'b0;
        tick(); tick();
        check_eq("midrst.bits", {29'd0, log_so[1], log_so[2], log_so[3]}, 32'h6);
        check_eq("midrst.queued", 32'(cnt_a), 32'd1);
        rec_on = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("midrst.out", {27'd0, dr_a, so_a, fd_a, bz_a, rdy_a}, 32'h1);
        check_eq("midrst.cnt", 32'(cnt_a), 32'd0);
        tick(); tick();
        check_eq("midrst.flushed", {30'd0, dr_a, bz_a}, 32'h0);

        start_log(1'b0);
        din_a = 8'h55; valid_a = 1'b1; tick(); valid_a = 1'b0;
        repeat (14) tick();
        exp_bytes = '{8'h55};
        analyze("post_rst", 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
